// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg
//   Shared types and constants for the AXI4-Lite configuration arbiter:
//   the transfer FSM state encoding, AXI response codes and the default
//   response-wait limit used by the optional timeout logic.
//   The DRAIN state only exists when AXIL_ARB_TIMEOUT_EN is defined.
package axil_arb_pkg;

    // Transfer sequencer states. DRAIN absorbs a response that arrives
    // after the requester has already been answered with SLVERR.
    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
`ifdef AXIL_ARB_TIMEOUT_EN
        DONE,
        DRAIN
`else
        DONE
`endif
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/axil_cfg_arbiter_if.sv
// axil_cfg_arbiter_if
//   AXI4-Lite bus bundle between the configuration arbiter (master) and the
//   audio pipeline register block (slave).
//   Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/
//   wready), B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//   R (rdata/rresp/rvalid/rready).
//   Modports: master drives addresses, data, valids and response readies;
//   slave drives the readies for AW/W/AR and the B/R responses.
interface axil_cfg_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant. A lone request is granted directly; on a tie
//   the requester that was not granted last wins. The last-granted pointer
//   resets to 1 so requester 0 wins the first tie after reset.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req[1:0]     request lines
//     accept       the current grant is being taken; updates the pointer
//     grant_valid  at least one request is pending
//     grant_idx    index of the selected requester
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_q;

    // Grant selection: a tie goes to whoever was not served last.
    always_comb begin
        grant_valid = |req;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_q;
            default: grant_idx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept && grant_valid) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/axil_cfg_arbiter.sv
// axil_cfg_arbiter
//   Shares the single AXI4-Lite slave port of the audio pipeline register
//   block between two configuration masters. One request is taken at a time,
//   chosen round-robin, and turned into one complete AXI4-Lite write
//   (AW+W+B) or read (AR+R). The requester gets a one-cycle req_ready pulse
//   together with the read data and response.
//   Ports:
//     ACLK, ARESETN  clock, asynchronous active-low reset
//     req_valid[i], req_write[i], req_addr slice i, req_wdata slice i
//                    per-requester request, held stable until req_ready[i]
//     req_ready[1:0] one-cycle completion pulse to the granted requester
//     rsp_rdata      read data, non-zero only during req_ready
//     rsp_resp       BRESP/RRESP of the finished transfer
//     m_axi          AXI4-Lite master port (axil_cfg_arbiter_if.master)
//   Build option: define AXIL_ARB_TIMEOUT_EN to bound the response wait to
//   TIMEOUT_CYCLES; the requester then gets SLVERR and the late response is
//   drained. Without it the block waits for the response indefinitely.
module axil_cfg_arbiter
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axil_cfg_arbiter_if.master      m_axi
);

    arb_state_t state_q, state_d;

    logic arb_valid, arb_idx, accept;
    logic grant_q, write_q;
    logic aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic                  awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                  awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            req_ready_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [1:0]            rsp_resp_d;

    assign accept = (state_q == IDLE) && arb_valid;

    rr_arb2 u_rr_arb2 (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .req         (req_valid),
        .accept      (accept),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign aw_hs = awvalid_q && m_axi.awready;
    assign w_hs  = wvalid_q  && m_axi.wready;
    assign b_hs  = bready_q  && m_axi.bvalid;
    assign ar_hs = arvalid_q && m_axi.arready;
    assign r_hs  = rready_q  && m_axi.rvalid;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout_hit, timeout_now, timed_out_q;

    assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_now = timeout_hit &&
                         (((state_q == WRESP) && !b_hs) ||
                          ((state_q == RDATA) && !r_hs));

    // Counts cycles spent waiting in WRESP/RDATA; restarts on every entry.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (((state_d == WRESP) || (state_d == RDATA)) && (state_d == state_q)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
            timed_out_q <= timeout_now;
        end
    end
`endif

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. WADDR waits for both AW and W handshakes, which may
    // complete in either order or together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = req_write[arb_idx] ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_d = DONE;
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (timeout_now) begin
                    state_d = DONE;
                end
`endif
            end
            RADDR: begin
                if (ar_hs) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    state_d = DONE;
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (timeout_now) begin
                    state_d = DONE;
                end
`endif
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            DONE: begin
                state_d = timed_out_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (write_q ? b_hs : r_hs) begin
                    state_d = IDLE;
                end
            end
`else
            DONE: begin
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computes the value every registered output takes in the
    // next state, so all bus outputs come straight from flops. The response
    // is captured on the same edge that enters DONE and is zero elsewhere.
    always_comb begin
        aw_done_d   = (state_q == WADDR) && (aw_done_q || aw_hs);
        w_done_d    = (state_q == WADDR) && (w_done_q  || w_hs);
        awvalid_d   = (state_d == WADDR) && !aw_done_d;
        wvalid_d    = (state_d == WADDR) && !w_done_d;
        arvalid_d   = (state_d == RADDR);
        bready_d    = (state_d == WRESP);
        rready_d    = (state_d == RDATA);
`ifdef AXIL_ARB_TIMEOUT_EN
        bready_d    = bready_d || ((state_d == DRAIN) &&  write_q);
        rready_d    = rready_d || ((state_d == DRAIN) && !write_q);
`endif
        req_ready_d = 2'b00;
        if (state_d == DONE) begin
            req_ready_d[grant_q] = 1'b1;
        end
        rsp_rdata_d = '0;
        rsp_resp_d  = RESP_OKAY;
        if ((state_q == RDATA) && r_hs) begin
            rsp_rdata_d = m_axi.rdata;
            rsp_resp_d  = m_axi.rresp;
        end
        if ((state_q == WRESP) && b_hs) begin
            rsp_resp_d  = m_axi.bresp;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        if (timeout_now) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_SLVERR;
        end
`endif
    end

    // Output and request-latch registers. The request payload is copied at
    // grant time so later changes on req_* have no effect on the transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            req_ready <= 2'b00;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            grant_q   <= 1'b0;
            write_q   <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            req_ready <= req_ready_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
            if (accept) begin
                grant_q <= arb_idx;
                write_q <= req_write[arb_idx];
                if (req_write[arb_idx]) begin
                    awaddr_q <= arb_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
                    wdata_q  <= arb_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_wdata[DATA_WIDTH-1:0];
                end else begin
                    araddr_q <= arb_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
